id_ex_stage: RTL

- ID/EX pipeline register that feeds the ALU with `alu_op`, `r1` and `r2`.
- Captures decoded instructions and resolves RAW hazards:
  - forwarding from MEM/WB at capture;
  - distance-1 bypass from the ALU result on the output side;
  - load-use stall generation.
- Also supports pipeline hold (downstream stall) and flush (branch redirect).

---
 rtl/id_ex_stage_pkg.sv | 23 ++
 rtl/id_ex_stage_fwd_select.sv | 29 ++
 rtl/id_ex_stage.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared widths, ALU opcode encodings and the control-bit bundle
// carried through the ID/EX register.
package id_ex_stage_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned REGW     = 5;
  localparam int unsigned OPW_DEF  = 5;

  localparam logic [OPW_DEF-1:0] OP_ADD = 5'd0;
  localparam logic [OPW_DEF-1:0] OP_SUB = 5'd1;
  localparam logic [OPW_DEF-1:0] OP_AND = 5'd2;
  localparam logic [OPW_DEF-1:0] OP_OR  = 5'd3;

  // A bubble issues ADD so the ALU result is well defined but ignored.
  localparam logic [OPW_DEF-1:0] NOP_OP_DEF = OP_ADD;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
  } ctrl_t;

endpackage

// File: rtl/id_ex_stage_fwd_select.sv
// Per-operand source select at capture: x0, then MEM, then WB, then regfile.
module id_ex_stage_fwd_select
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [REGW-1:0] rs,
  input  logic [XLEN-1:0] rf_data,
  input  logic            mem_we,
  input  logic [REGW-1:0] mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_we,
  input  logic [REGW-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] opnd_c
);

  always_comb begin
    opnd_c = rf_data;
    if (rs == '0) begin
      opnd_c = '0;
    end else if (mem_we && (mem_rd == rs)) begin
      opnd_c = mem_data;
    end else if (wb_we && (wb_rd == rs)) begin
      opnd_c = wb_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded instructions with MEM/WB
// forwarding, bypasses the ALU result one instruction back, and raises load-use stalls.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned     XLEN   = XLEN_DEF,
  parameter int unsigned     OPW    = OPW_DEF,
  parameter logic [OPW-1:0]  NOP_OP = NOP_OP_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [OPW-1:0]  id_alu_op,
  input  logic [REGW-1:0] id_rs1,
  input  logic [REGW-1:0] id_rs2,
  input  logic [REGW-1:0] id_rd,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic            id_use_imm,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic [REGW-1:0] mem_rd,
  input  logic            mem_we,
  input  logic [XLEN-1:0] mem_data,
  input  logic [REGW-1:0] wb_rd,
  input  logic            wb_we,
  input  logic [XLEN-1:0] wb_data,
  input  logic [XLEN-1:0] alu_res,
  input  logic            ex_stall,
  input  logic            flush,
  output logic            ex_valid,
  output logic [OPW-1:0]  ex_alu_op,
  output logic [XLEN-1:0] ex_r1,
  output logic [XLEN-1:0] ex_r2,
  output logic [XLEN-1:0] ex_store_data,
  output logic [REGW-1:0] ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            id_stall
);

  logic            valid_q,    valid_d;
  logic [OPW-1:0]  alu_op_q,   alu_op_d;
  logic [XLEN-1:0] r1_q,       r1_d;
  logic [XLEN-1:0] r2_q,       r2_d;
  logic [XLEN-1:0] imm_q,      imm_d;
  logic            use_imm_q,  use_imm_d;
  logic [REGW-1:0] rd_q,       rd_d;
  ctrl_t           ctrl_q,     ctrl_d;
  logic            fwd1_rs1_q, fwd1_rs1_d;
  logic            fwd1_rs2_q, fwd1_rs2_d;

  logic [XLEN-1:0] rs1_sel_c;
  logic [XLEN-1:0] rs2_sel_c;
  logic            load_use_c;
  logic            ex_fwd_src_c;
  logic [XLEN-1:0] rs2v_c;

  id_ex_stage_fwd_select #(.XLEN(XLEN)) u_fwd_rs1 (
    .rs       (id_rs1),
    .rf_data  (id_rs1_data),
    .mem_we   (mem_we),
    .mem_rd   (mem_rd),
    .mem_data (mem_data),
    .wb_we    (wb_we),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .opnd_c   (rs1_sel_c)
  );

  id_ex_stage_fwd_select #(.XLEN(XLEN)) u_fwd_rs2 (
    .rs       (id_rs2),
    .rf_data  (id_rs2_data),
    .mem_we   (mem_we),
    .mem_rd   (mem_rd),
    .mem_data (mem_data),
    .wb_we    (wb_we),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data),
    .opnd_c   (rs2_sel_c)
  );

  // rs2 only matters for a hazard when it feeds the ALU or the store data.
  always_comb begin
    load_use_c = valid_q && ctrl_q.mem_read && (rd_q != '0) && id_valid &&
                 ((id_rs1 == rd_q) ||
                  ((!id_use_imm || id_mem_write) && (id_rs2 == rd_q)));
    id_stall   = !rst && (load_use_c || ex_stall);
    // Only a non-load writer in EX can hand its result over next cycle.
    ex_fwd_src_c = valid_q && ctrl_q.reg_write && !ctrl_q.mem_read && (rd_q != '0);
  end

  always_comb begin
    valid_d    = valid_q;
    alu_op_d   = alu_op_q;
    r1_d       = r1_q;
    r2_d       = r2_q;
    imm_d      = imm_q;
    use_imm_d  = use_imm_q;
    rd_d       = rd_q;
    ctrl_d     = ctrl_q;
    fwd1_rs1_d = fwd1_rs1_q;
    fwd1_rs2_d = fwd1_rs2_q;
    if (!ex_stall) begin
      if (flush || load_use_c) begin
        valid_d    = 1'b0;
        alu_op_d   = NOP_OP;
        use_imm_d  = 1'b0;
        rd_d       = '0;
        ctrl_d     = '0;
        fwd1_rs1_d = 1'b0;
        fwd1_rs2_d = 1'b0;
      end else begin
        valid_d    = id_valid;
        alu_op_d   = id_valid ? id_alu_op : NOP_OP;
        r1_d       = rs1_sel_c;
        r2_d       = rs2_sel_c;
        imm_d      = id_imm;
        use_imm_d  = id_use_imm;
        rd_d       = id_rd;
        ctrl_d     = id_valid ? ctrl_t'{id_reg_write, id_mem_read, id_mem_write} : '0;
        fwd1_rs1_d = id_valid && ex_fwd_src_c && (rd_q == id_rs1);
        fwd1_rs2_d = id_valid && ex_fwd_src_c && (rd_q == id_rs2);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      alu_op_q   <= NOP_OP;
      r1_q       <= '0;
      r2_q       <= '0;
      imm_q      <= '0;
      use_imm_q  <= 1'b0;
      rd_q       <= '0;
      ctrl_q     <= '0;
      fwd1_rs1_q <= 1'b0;
      fwd1_rs2_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      alu_op_q   <= alu_op_d;
      r1_q       <= r1_d;
      r2_q       <= r2_d;
      imm_q      <= imm_d;
      use_imm_q  <= use_imm_d;
      rd_q       <= rd_d;
      ctrl_q     <= ctrl_d;
      fwd1_rs1_q <= fwd1_rs1_d;
      fwd1_rs2_q <= fwd1_rs2_d;
    end
  end

  always_comb begin
    rs2v_c        = fwd1_rs2_q ? alu_res : r2_q;
    ex_valid      = valid_q;
    ex_alu_op     = alu_op_q;
    ex_rd         = rd_q;
    ex_r1         = fwd1_rs1_q ? alu_res : r1_q;
    ex_r2         = use_imm_q ? imm_q : rs2v_c;
    ex_store_data = rs2v_c;
    ex_reg_write  = valid_q && ctrl_q.reg_write;
    ex_mem_read   = valid_q && ctrl_q.mem_read;
    ex_mem_write  = valid_q && ctrl_q.mem_write;
  end

endmodule
